qmult_rr_sched: RTL

- Round-robin scheduler that shares a single fixed-point multiplier (qmult, Q-format sign-magnitude) between NREQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The scheduler grants one requester, runs the multiply, and returns a registered result, tagged with the requester id, on a single response channel.
- Sits between datapath stages that each need occasional multiplies and cannot each afford a multiplier.

---
 rtl/qmult_rr_sched.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/qmult_rr_sched.sv
// Round-robin scheduler sharing one Q-format fixed-point multiplier among NREQ requesters.
// Latency: grant edge T -> response valid after edge T+1; at least 3 cycles per transaction.
// Backpressure: response is held in RESP until i_rsp_ready; no new grants until it drains.

// Combinational fixed-point multiply on magnitudes, sign applied afterwards, truncating.
module qmult #(
    parameter int Q = 8,
    parameter int N = 16
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_result,
    output logic         o_ovr
);
    logic [N-1:0]   mag_a;
    logic [N-1:0]   mag_b;
    logic [N-1:0]   res_mag;
    logic [2*N-1:0] product;
    logic           unused_prod;

    // Multiply magnitudes, take the Q-aligned window, negate if the signs differ
    always_comb begin
        mag_a    = i_a[N-1] ? -i_a : i_a;
        mag_b    = i_b[N-1] ? -i_b : i_b;
        product  = {{N{1'b0}}, mag_a} * {{N{1'b0}}, mag_b};
        res_mag  = {1'b0, product[N-2+Q:Q]};
        o_result = (i_a[N-1] ^ i_b[N-1]) ? -res_mag : res_mag;
        o_ovr    = |product[2*N-2:N-1+Q];
    end

    // Truncated fraction bits and the top product bit are intentionally dropped
    assign unused_prod = ^{product[2*N-1], product[Q-1:0]};
endmodule

module qmult_rr_sched #(
    parameter int Q    = 8,
    parameter int N    = 16,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NREQ-1:0]   i_req_valid,
    input  logic [NREQ*N-1:0] i_req_a,
    input  logic [NREQ*N-1:0] i_req_b,
    output logic [NREQ-1:0]   o_req_ready,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [N-1:0]      o_rsp_data,
    output logic [IDW-1:0]    o_rsp_id,
    output logic              o_rsp_ovr,
    output logic              o_ovr_sticky,
    input  logic              i_ovr_clr,
    output logic              o_busy
);
    localparam int IW1 = IDW + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_RESP} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [IDW-1:0] id_q, id_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [N-1:0]   rsp_data_q, rsp_data_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic           rsp_ovr_q, rsp_ovr_d;
    logic           sticky_q, sticky_d;

    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic [IW1-1:0] cand;
    logic [N-1:0]   a_sel;
    logic [N-1:0]   b_sel;
    logic [NREQ-1:0] req_rdy;
    logic [N-1:0]   mul_res;
    logic           mul_ovr;

    // Round-robin search: first valid requester after the last one served, wrapping
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_q} + IW1'(i + 1);
            if (cand >= IW1'(NREQ)) begin
                cand = cand - IW1'(NREQ);
            end
            if (!gnt_found && i_req_valid[cand[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDW-1:0];
            end
        end
    end

    // Operand mux for the winner and one-hot accept strobe, only offered in IDLE
    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        req_rdy = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_idx == IDW'(k)) begin
                a_sel      = i_req_a[k*N +: N];
                b_sel      = i_req_b[k*N +: N];
                req_rdy[k] = gnt_found && (state_q == S_IDLE);
            end
        end
    end

    qmult #(.Q(Q), .N(N)) u_qmult (
        .i_a      (a_q),
        .i_b      (b_q),
        .o_result (mul_res),
        .o_ovr    (mul_ovr)
    );

    // Next-state: grant in IDLE, sample the multiplier in CALC, hold until accepted in RESP
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_ovr_d   = rsp_ovr_q;
        sticky_d    = i_ovr_clr ? 1'b0 : sticky_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    a_d     = a_sel;
                    b_d     = b_sel;
                    id_d    = gnt_idx;
                    ptr_d   = gnt_idx;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                rsp_data_d  = mul_res;
                rsp_ovr_d   = mul_ovr;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                // A fresh overflow beats a simultaneous clear
                if (mul_ovr) begin
                    sticky_d = 1'b1;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset abandons any transaction in flight
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= IDW'(NREQ - 1);
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_ovr_q   <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_ovr_q   <= rsp_ovr_d;
            sticky_q    <= sticky_d;
        end
    end

    assign o_req_ready  = req_rdy;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_data   = rsp_data_q;
    assign o_rsp_id     = rsp_id_q;
    assign o_rsp_ovr    = rsp_ovr_q;
    assign o_ovr_sticky = sticky_q;
    assign o_busy       = (state_q != S_IDLE);
endmodule
